led_matrix_scan_controller: RTL and testbench
=============================================

LED_MATRIX_SCAN_CONTROLLER -- requirements
Module: led_matrix_scan_controller

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000: clk cycles per column slot, legal range 4..2^20.
REQ-002 SHALL have parameter BLINK_FRAMES, default 25: frames per blink half-period, legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1 bit: high runs the scan; low blanks the display and holds the counters.
REQ-006 SHALL have port irrigation_status, input, 2 bits: current irrigation condition code.
REQ-007 SHALL have port columns, output, 5 bits: column drives, one-hot, active-low.
REQ-008 SHALL have port rows, output, 7 bits: row drives, active-high.
REQ-009 SHALL have port frame_done, output, 1 bit: one-cycle pulse when column 4 hands over to column 0.

Function
REQ-010 SHALL count tick_cnt from 0 to CLK_DIV-1 while enable=1, wrapping to 0, and assert an internal tick in the cycle tick_cnt=CLK_DIV-1.
REQ-011 SHALL advance col_idx by one on each tick (0,1,2,3,4,0,...), wrapping 4->0.
REQ-012 SHALL drive columns=5'b11111 (blank) for exactly the one cycle after each tick, then drive column col_idx low for the rest of the slot (anti-ghosting).
REQ-013 SHALL register rows from the image sub-module output for (status_latched, col_idx), and SHALL update rows only during the blank cycle.
REQ-014 SHALL latch irrigation_status into status_latched only on the tick that wraps col_idx from 4 to 0, so a whole frame shows one status; mid-frame changes SHALL wait for the next frame.
REQ-015 SHALL pulse frame_done for one cycle, on the cycle after the 4->0 tick, together with the blank cycle.
REQ-016 SHALL blank at once while enable=0 (columns=5'b11111, rows=0) and hold tick_cnt and col_idx; when enable returns to 1, counting SHALL resume from the held values.
REQ-017 SHALL count the whole visible frame at 5*CLK_DIV cycles; the blank cycle is part of that count.
REQ-018 SHALL have all outputs registered, with no combinational path from input to output.

Reset
REQ-019 SHALL on reset set tick_cnt=0, col_idx=0, status_latched=2'b00, columns=5'b11111, rows=7'b0, frame_done=0 and the blink state to visible.
REQ-020 SHALL, on reset asserted mid-frame, blank at once without waiting for a clock; after release, the first column-0 drive SHALL come after one full CLK_DIV period.
REQ-021 SHALL after reset release display status 2'b00 until the first 4->0 wrap.

Configuration
REQ-022 SHALL, with macro LED_MATRIX_BLINK_ALERT_EN defined, count frames while status_latched=2'b11 and toggle visibility every BLINK_FRAMES frames; while invisible, rows=0 and columns keep scanning.
REQ-023 SHALL, with the macro defined, clear the blink counter and force visible whenever status_latched is not 2'b11.
REQ-024 SHALL, without the macro, leave out all blink logic, with status 2'b11 shown steadily.

Structure
REQ-025 SHALL take NUM_COLS=5, NUM_ROWS=7 and the status code constants (2'b00..2'b11) from the shared LED-matrix include/package, with no local copies.
REQ-026 SHALL instantiate a single combinational sub-module, irrigation_status_image, that chooses among the five per-column status decoders by col_idx.

Verification
REQ-027 SHALL cover: CLK_DIV=4, reset release -> columns sequence 11111x4, 11111, 11110x3, 11111, 11101x3 ... and col 4 -> col 0 with frame_done high for 1 cycle every 20 cycles.
REQ-028 SHALL cover: status 00->01 at col_idx=2 -> rows stay the 00 image for cols 2-4; the 01 image shows from col 0 of the next frame.
REQ-029 SHALL cover: enable=0 for 7 cycles mid-slot -> columns=11111, rows=0; slot resumes with the remaining tick_cnt count unchanged.
REQ-030 SHALL cover: reset pulse between edges in the middle of col 3 -> columns=11111 at once, col_idx=0, status_latched=00.
REQ-031 SHALL cover, with the macro defined, BLINK_FRAMES=2, status 11: rows zero in frames 3-4, visible in frames 5-6; status 01 -> always visible.
REQ-032 SHALL cover: rows in every slot equal the irrigation_status_image output for (status_latched, col_idx), checked by a scoreboard over all four statuses.

Source files
------------

// File: rtl/led_matrix_scan_controller_pkg.sv
// led_matrix_scan_controller_pkg: shared LED-matrix geometry, irrigation status codes and glyphs.
package led_matrix_scan_controller_pkg;
   localparam int NUM_COLS = 5;
   localparam int NUM_ROWS = 7;
   localparam int COL_W = $clog2(NUM_COLS);
   typedef enum logic [1:0] {
      ST_OK    = 2'b00,
      ST_DRY   = 2'b01,
      ST_WET   = 2'b10,
      ST_ALERT = 2'b11
   } status_e;
   // Row bit 0 is the top LED; one entry per column, column 0 first.
   localparam logic [NUM_ROWS-1:0] GLYPH [4][NUM_COLS] = '{
      '{7'h08, 7'h10, 7'h20, 7'h04, 7'h02},
      '{7'h1c, 7'h22, 7'h41, 7'h22, 7'h1c},
      '{7'h1c, 7'h3e, 7'h7f, 7'h3e, 7'h1c},
      '{7'h41, 7'h22, 7'h5f, 7'h22, 7'h41}
   };
   function automatic logic [NUM_COLS-1:0] col_drive(input logic [COL_W-1:0] c);
      return ~(NUM_COLS'(1) << c);
   endfunction
endpackage

// File: rtl/led_matrix_scan_controller_image.sv
// irrigation_status_image: row pattern for (status, col); five per-column decoders selected by col.
module irrigation_status_image
   import led_matrix_scan_controller_pkg::*;
(
   input  logic [1:0]          status,
   input  logic [COL_W-1:0]    col,
   output logic [NUM_ROWS-1:0] rows
);
   logic [NUM_ROWS-1:0] dec [NUM_COLS];
   for (genvar c = 0; c < NUM_COLS; c++) begin : g_dec
      assign dec[c] = GLYPH[status][c];
   end
   assign rows = (col < COL_W'(NUM_COLS)) ? dec[col] : '0;
endmodule

// File: rtl/led_matrix_scan_controller.sv
// led_matrix_scan_controller: 5x7 column-scan driver showing the irrigation status glyph.
// Define LED_MATRIX_BLINK_ALERT_EN to blink the alert (2'b11) glyph every BLINK_FRAMES frames.
module led_matrix_scan_controller
   import led_matrix_scan_controller_pkg::*;
#(
   parameter int CLK_DIV      = 50000,
   parameter int BLINK_FRAMES = 25
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [1:0]          irrigation_status,
   output logic [NUM_COLS-1:0] columns,
   output logic [NUM_ROWS-1:0] rows,
   output logic                frame_done
);
   localparam int TW = $clog2(CLK_DIV);
   if (CLK_DIV < 4 || CLK_DIV > (1 << 20) || BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_bad_param
      $error("led_matrix_scan_controller: CLK_DIV or BLINK_FRAMES out of range");
   end
   logic [TW-1:0]       tick_cnt;
   logic [COL_W-1:0]    col_idx;
   logic [1:0]          status_latched;
   logic                live, blank_q, en_q, tick, wrap, show;
   logic [NUM_ROWS-1:0] img;
   assign tick = enable && tick_cnt == TW'(CLK_DIV - 1);
   assign wrap = tick && live && col_idx == COL_W'(NUM_COLS - 1);
   irrigation_status_image u_image (
      .status (status_latched),
      .col    (col_idx),
      .rows   (img)
   );
   // live stays low for the first slot after reset so column 0 gets a full slot of its own.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tick_cnt       <= '0;
         col_idx        <= '0;
         status_latched <= ST_OK;
         live           <= 1'b0;
         blank_q        <= 1'b0;
         en_q           <= 1'b0;
         columns        <= '1;
         rows           <= '0;
         frame_done     <= 1'b0;
      end else begin
         en_q       <= enable;
         frame_done <= wrap;
         if (enable) begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            blank_q  <= tick;
         end
         if (tick) live <= 1'b1;
         if (tick && live) col_idx <= wrap ? '0 : col_idx + 1'b1;
         if (wrap) status_latched <= irrigation_status;
         columns <= (!enable || tick || !live) ? '1 : col_drive(col_idx);
         // Rows reload only while the columns are blank, or when a paused slot resumes.
         rows <= !enable ? '0 : (blank_q || !en_q) ? ((live && show) ? img : '0) : rows;
      end
   end
`ifdef LED_MATRIX_BLINK_ALERT_EN
   logic [7:0] blink_cnt;
   logic       visible;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt <= '0;
         visible   <= 1'b1;
      end else if (status_latched != ST_ALERT) begin
         blink_cnt <= '0;
         visible   <= 1'b1;
      end else if (wrap) begin
         blink_cnt <= (blink_cnt == 8'(BLINK_FRAMES - 1)) ? '0 : blink_cnt + 1'b1;
         visible   <= (blink_cnt == 8'(BLINK_FRAMES - 1)) ? !visible : visible;
      end
   end
   // A non-alert status is visible at once, even before the blink state has cleared.
   assign show = visible || status_latched != ST_ALERT;
`else
   assign show = 1'b1;
`endif
endmodule

// File: tb/tb_led_matrix_scan_controller.sv
// tb_led_matrix_scan_controller: scoreboard bench for the LED matrix scan controller (CLK_DIV=4).
module tb_led_matrix_scan_controller;
   localparam int CD = 4;
   localparam int BF = 2;
`ifdef LED_MATRIX_BLINK_ALERT_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif
   typedef struct packed {
      logic [4:0] cols;
      logic [6:0] rows;
   } exp_t;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b1;
   logic [1:0] irrigation_status = 2'b00;
   logic [4:0] columns;
   logic [6:0] rows;
   logic       frame_done;
   int         n_tests = 0;
   int         n_fail = 0;
   exp_t       sb_q [$];
   exp_t       cur = '0;
   bit         mon_on = 1'b0;
   int         cyc = 0;
   int         last_fd = -1;
   logic [4:0] prev_cols = 5'h1f;
   int         run = 0;
   logic [1:0] prev_st = 2'b00;
   logic [6:0] glyph [4][5] = '{
      '{7'h08, 7'h10, 7'h20, 7'h04, 7'h02},
      '{7'h1c, 7'h22, 7'h41, 7'h22, 7'h1c},
      '{7'h1c, 7'h3e, 7'h7f, 7'h3e, 7'h1c},
      '{7'h41, 7'h22, 7'h5f, 7'h22, 7'h41}
   };
   logic [1:0] seq [12] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd0, 2'd3, 2'd2};
   logic [4:0] col_seq [16] = '{5'h1f, 5'h1f, 5'h1f, 5'h1f, 5'h1f, 5'h1e, 5'h1e, 5'h1e,
                                5'h1f, 5'h1d, 5'h1d, 5'h1d, 5'h1f, 5'h1b, 5'h1b, 5'h1b};

   led_matrix_scan_controller #(.CLK_DIV(CD), .BLINK_FRAMES(BF)) dut (
      .clk               (clk),
      .reset             (reset),
      .enable            (enable),
      .irrigation_status (irrigation_status),
      .columns           (columns),
      .rows              (rows),
      .frame_done        (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected frame: glyph columns 0..4, rows dark in the blink-off half of an alert run.
   task automatic push_frame(input logic [1:0] st);
      exp_t e;
      bit   vis;
      run = (st == 2'b11 && prev_st == 2'b11) ? run + 1 : 0;
      prev_st = st;
      vis = !BLINK || st != 2'b11 || ((run / BF) % 2 == 0);
      for (int c = 0; c < 5; c++) begin
         e.cols = 5'h1f ^ (5'h01 << c);
         e.rows = vis ? glyph[st][c] : 7'h00;
         sb_q.push_back(e);
      end
   endtask

   task automatic wait_frame();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_done && n < 12 * CD);
      check("frame_wait", frame_done, 1);
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         if (frame_done) begin
            check("fd_blank", columns, 5'h1f);
            if (last_fd >= 0) check("fd_period", cyc - last_fd, 5 * CD);
            last_fd = cyc;
         end
         if (columns != 5'h1f) begin
            if (prev_cols == 5'h1f) begin
               check("sb_avail", sb_q.size() != 0, 1);
               if (sb_q.size() != 0) cur = sb_q.pop_front();
            end
            check("sb_cols", columns, cur.cols);
            check("sb_rows", rows, cur.rows);
         end
         prev_cols = columns;
         cyc++;
      end
   end

   initial begin
      int n;
      irrigation_status = seq[0];
      repeat (3) @(negedge clk);
      check("rst_cols", columns, 5'h1f);
      check("rst_rows", rows, 7'h00);
      check("rst_fd", frame_done, 0);
      push_frame(2'b00);
      push_frame(seq[0]);
      mon_on = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         check($sformatf("col_seq%0d", k), columns, col_seq[k]);
      end
      for (int i = 1; i < 12; i++) begin
         wait_frame();
         repeat (2 * CD + 1) @(negedge clk);
         irrigation_status = seq[i];
         push_frame(seq[i]);
      end
      wait_frame();
      wait_frame();
      check("sb_drain", sb_q.size(), 0);
      mon_on = 1'b0;
      // Pause mid-slot in column 0 of a status-2 frame.
      @(negedge clk);
      check("pause_pre", columns, 5'h1e);
      enable = 1'b0;
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         check("pause_cols", columns, 5'h1f);
         check("pause_rows", rows, 7'h00);
      end
      enable = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         if (columns == 5'h1e) begin
            check("resume_rows", rows, glyph[2][0]);
            n++;
         end
      end while (columns == 5'h1e && n < 10);
      check("resume_left", n, CD - 2);
      check("resume_blank", columns, 5'h1f);
      @(negedge clk);
      check("resume_next", columns, 5'h1d);
      // Asynchronous reset pulse between edges in the column 3 slot.
      wait_frame();
      repeat (3 * CD + 1) @(negedge clk);
      check("pre_rst_col3", columns, 5'h17);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("arst_cols", columns, 5'h1f);
      check("arst_rows", rows, 7'h00);
      check("arst_fd", frame_done, 0);
      #1 reset = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         if (columns == 5'h1f) n++;
      end while (columns == 5'h1f && n < 20);
      check("arst_preroll", n, CD + 1);
      check("arst_col0", columns, 5'h1e);
      check("arst_rows00", rows, glyph[0][0]);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
      $fatal(1);
   end
endmodule
